load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-side initiator for the word-wide `DataMem` port. It accepts RV32I load/store requests from the execute stage and drives `memAddr`/`memReadEnable`/`memWriteEnable`/`memWriteData`. It handles byte/half/word access with sign or zero extension, and performs read-modify-write for sub-word stores. It returns one response per request to the writeback stage, flagging misaligned, out-of-range and illegal accesses without touching memory.

## Interface
- `MEM_BYTES`, default 4096: size of the data memory in bytes. Any byte address ≥ MEM_BYTES is out of range.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  unit idle and able to accept a request.
- `reqWrite`  in  1  1 = store, 0 = load.
- `reqFunct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU. BU and HU are legal for loads only.
- `reqAddr`  in  32  byte address.
- `reqData`  in  32  store data, with the low byte/half used for SB/SH.
- `respValid`  out  1  one-cycle pulse when the request completes.
- `respData`  out  32  extended load result; 0 for stores and errors.
- `respError`  out  1  valid with `respValid`: misaligned, out of range, or illegal funct3.
- `memAddr`  out  32  word-aligned address `{reqAddr[31:2],2'b00}`; 0 when idle.
- `memReadEnable`  out  1  read strobe.
- `memReadData`  in  32  valid in the cycle after the cycle `memReadEnable` is high.
- `memWriteEnable`  out  1  write strobe; memory writes on the rising edge while it is high.
- `memWriteData`  out  32  full merged word.

## Operation
- States: IDLE, RD, WAIT, WR, DONE.
- Request capture: in IDLE, `reqValid`=1 latches the request (addr, funct3, write, data). `reqValid` is ignored outside IDLE.
- Acceptance check, at the accepting edge:
  - Error if: halfword with addr[0]≠0; word with addr[1:0]≠0; addr ≥ MEM_BYTES; funct3 ∉ legal set; store with BU or HU.
  - On error → DONE with the error flag set; no memory strobes are ever issued for the request.
- Transitions from IDLE on a legal request:
  - Load → RD.
  - SW → WR.
  - SB/SH → RD (read-modify-write).
- RD: `memReadEnable`=1 for exactly one cycle → WAIT.
- WAIT: the word register captures `memReadData`.
  - Load → DONE.
  - SB/SH → WR.
- Load extraction is little-endian on the captured word:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
  - The result is registered into `respData` on the WAIT→DONE edge.
- WR: `memWriteEnable`=1 for exactly one cycle → DONE.
  - SW: `memWriteData`=reqData.
  - SB/SH: the captured word with only the addressed byte/half replaced by reqData[7:0]/[15:0].
- DONE: `respValid`=1 for one cycle, with `respError` and `respData` held stable → IDLE.
- Responses have no backpressure; the consumer must sample `respValid` in the cycle it is high.

## Timing
- Reset: state=IDLE, `reqReady`=1, and every other output = 0, including all strobes, `memAddr` and `respData`.
- Reset mid-operation aborts the request immediately and produces no response. A reset asserted during WR deasserts `memWriteEnable` combinationally with the state clear.
- `reqReady`=1 only in IDLE.
- Cycles from the accepting edge to the `respValid` cycle (accept cycle = 0):
  - Error: 1.
  - SW: 2.
  - Load: 3.
  - SB/SH: 4.
- `memAddr` is stable and aligned during RD, WAIT and WR.
- At most one strobe is high per cycle. Read and write are never simultaneous.
- Back-to-back: the next request can be accepted in the cycle after DONE, i.e. the IDLE cycle following `respValid`.

## Structure
- Package `lsu_pkg` holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum/localparams for IDLE, RD, WAIT, WR, DONE;
  - the lane-select width constant.
- One combinational sub-module, `lsu_align`:
  - inputs: word, addr[1:0], funct3, store data;
  - outputs: extended load value and merged store word.
- The FSM, request registers and word register stay in `load_store_unit`.

## Test plan
- **Word round trip:** SW addr 0x200, data 0xDEADBEEF → one write strobe with memAddr=0x200 and memWriteData=0xDEADBEEF, respValid at cycle 2. Then LW 0x200 → respData=0xDEADBEEF at cycle 3, respError=0.
- **Byte and half loads:** word 0x8081F0F1 at 0x204.
  - LB 0x205 → 0xFFFFFFF0.
  - LBU 0x207 → 0x00000080.
  - LH 0x206 → 0xFFFF8081.
  - LHU 0x204 → 0x0000F0F1.
- **Sub-word store RMW:** word 0x11223344 at 0x208.
  - SB 0x209 data 0xAA → write 0x1122AA44 at cycle 3, respValid at cycle 4.
  - SH 0x20A data 0xBEEF → write 0xBEEFAA44.
- **Errors:** each of the following gives respError=1, respData=0, respValid at cycle 1, and zero memory strobes:
  - LW 0x201;
  - SH 0x203;
  - LW 0x1000 with MEM_BYTES=4096;
  - funct3=011;
  - store with funct3=100.
- **Reset mid-operation:**
  - Assert rst during WAIT of an SB → no write strobe ever, no respValid, reqReady=1 after reset. The memory word is unchanged on a subsequent LW.
  - Assert rst asynchronously during WR → memWriteEnable drops within the same cycle.
- **Handshake:**
  - Hold reqValid high with a changing reqAddr during a load → only the first request is served.
  - The next request is accepted in the cycle after respValid, and responses are delivered in order.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// and small decode helpers used at request acceptance.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-lane select width within a 32-bit word.
  localparam int LANE_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE
  } lsu_state_t;

  // Unsigned-extension variants only make sense for loads.
  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !write;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [LANE_W-1:0] lane);
    case (f3)
      F3_H, F3_HU: return lane[0];
      F3_W:        return (lane != '0);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundles for the load/store unit: request/response channel from the execute
// stage, and the word-wide data memory port.
interface lsu_req_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr;
  logic [31:0] reqData;
  logic        respValid;
  logic [31:0] respData;
  logic        respError;

  modport master (
    output reqValid, reqWrite, reqFunct3, reqAddr, reqData,
    input  reqReady, respValid, respData, respError
  );

  modport slave (
    input  reqValid, reqWrite, reqFunct3, reqAddr, reqData,
    output reqReady, respValid, respData, respError
  );
endinterface

interface lsu_mem_if;
  logic [31:0] memAddr;
  logic        memReadEnable;
  logic [31:0] memReadData;
  logic        memWriteEnable;
  logic [31:0] memWriteData;

  modport master (
    output memAddr, memReadEnable, memWriteEnable, memWriteData,
    input  memReadData
  );

  modport slave (
    input  memAddr, memReadEnable, memWriteEnable, memWriteData,
    output memReadData
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends a load value from a memory
// word, and merges sub-word store data into a word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0]       i_word,
  input  logic [LANE_W-1:0] i_lane,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_storeData,
  output logic [31:0]       o_loadData,
  output logic [31:0]       o_storeWord
);

  logic [4:0]         w_byteShift;
  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;
  logic signed [31:0] w_byteSext;
  logic signed [31:0] w_halfSext;

  // Little-endian: lane 0 is bits [7:0].
  assign w_byteShift = {i_lane, 3'b000};
  assign w_byte      = 8'(i_word >> w_byteShift);
  assign w_half      = i_lane[1] ? i_word[31:16] : i_word[15:0];
  assign w_byteSext  = w_byte;
  assign w_halfSext  = w_half;

  // Select and extend the addressed lane for loads.
  always_comb begin
    o_loadData = '0;
    case (i_funct3)
      F3_B:    o_loadData = w_byteSext;
      F3_BU:   o_loadData = {24'b0, w_byte};
      F3_H:    o_loadData = w_halfSext;
      F3_HU:   o_loadData = {16'b0, w_half};
      F3_W:    o_loadData = i_word;
      default: o_loadData = '0;
    endcase
  end

  // Replace only the addressed byte/half of the read word for sub-word stores.
  always_comb begin
    o_storeWord = i_storeData;
    case (i_funct3)
      F3_B:    o_storeWord = (i_word & ~(32'h0000_00FF << w_byteShift))
                           | ({24'b0, i_storeData[7:0]} << w_byteShift);
      F3_H:    o_storeWord = i_lane[1] ? {i_storeData[15:0], i_word[15:0]}
                                       : {i_word[31:16], i_storeData[15:0]};
      default: o_storeWord = i_storeData;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32I memory request at a time, sequences the
// word-wide memory port (with read-modify-write for SB/SH) and returns a
// single response. Illegal requests are answered without touching memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 4096
)
(
  input  logic      clk,
  input  logic      rst,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  lsu_state_t        r_state;
  logic              r_reqReady;
  logic              r_respValid;
  logic              r_respError;
  logic [31:0]       r_respData;
  logic [31:0]       r_memAddr;
  logic              r_memRe;
  logic              r_memWe;
  logic [31:0]       r_memWd;

  logic [LANE_W-1:0] r_lane;
  logic [2:0]        r_funct3;
  logic              r_write;
  logic [31:0]       r_data;
  logic [31:0]       r_word;

  logic              w_accept;
  logic              w_err;
  logic [31:0]       w_alignWord;
  logic [31:0]       w_loadData;
  logic [31:0]       w_storeWord;

  assign w_accept = (r_state == S_IDLE) && req.reqValid;
  assign w_err    = !f3_legal(req.reqWrite, req.reqFunct3)
                 || f3_misaligned(req.reqFunct3, req.reqAddr[LANE_W-1:0])
                 || (req.reqAddr >= MEM_LIMIT);

  // Read data is forwarded straight from memory in WAIT so the load result and
  // the merged store word can be registered on the WAIT exit edge.
  assign w_alignWord = (r_state == S_WAIT) ? mem.memReadData : r_word;

  lsu_align u_align (
    .i_word      (w_alignWord),
    .i_lane      (r_lane),
    .i_funct3    (r_funct3),
    .i_storeData (r_data),
    .o_loadData  (w_loadData),
    .o_storeWord (w_storeWord)
  );

  // Latch the request fields at acceptance; datapath only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lane   <= req.reqAddr[LANE_W-1:0];
      r_funct3 <= req.reqFunct3;
      r_write  <= req.reqWrite;
      r_data   <= req.reqData;
    end
  end

  // Word register holds the memory read for the RMW path.
  always_ff @(posedge clk) begin
    if (r_state == S_WAIT) begin
      r_word <= mem.memReadData;
    end
  end

  // Main FSM with registered strobes and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_reqReady  <= 1'b1;
      r_respValid <= 1'b0;
      r_respError <= 1'b0;
      r_respData  <= '0;
      r_memAddr   <= '0;
      r_memRe     <= 1'b0;
      r_memWe     <= 1'b0;
      r_memWd     <= '0;
    end else begin
      r_respValid <= 1'b0;
      r_memRe     <= 1'b0;
      r_memWe     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req.reqValid) begin
            r_reqReady <= 1'b0;
            r_respData <= '0;
            if (w_err) begin
              r_state     <= S_DONE;
              r_respValid <= 1'b1;
              r_respError <= 1'b1;
            end else begin
              r_respError <= 1'b0;
              r_memAddr   <= {req.reqAddr[31:2], 2'b00};
              if (req.reqWrite && (req.reqFunct3 == F3_W)) begin
                r_state <= S_WR;
                r_memWe <= 1'b1;
                r_memWd <= req.reqData;
              end else begin
                r_state <= S_RD;
                r_memRe <= 1'b1;
              end
            end
          end
        end
        S_RD: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_write) begin
            r_state <= S_WR;
            r_memWe <= 1'b1;
            r_memWd <= w_storeWord;
          end else begin
            r_state     <= S_DONE;
            r_respValid <= 1'b1;
            r_respData  <= w_loadData;
            r_memAddr   <= '0;
          end
        end
        S_WR: begin
          r_state     <= S_DONE;
          r_respValid <= 1'b1;
          r_memAddr   <= '0;
          r_memWd     <= '0;
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_reqReady  <= 1'b1;
          r_respError <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_reqReady <= 1'b1;
        end
      endcase
    end
  end

  assign req.reqReady       = r_reqReady;
  assign req.respValid      = r_respValid;
  assign req.respError      = r_respError;
  assign req.respData       = r_respData;
  assign mem.memAddr        = r_memAddr;
  assign mem.memReadEnable  = r_memRe;
  assign mem.memWriteEnable = r_memWe;
  assign mem.memWriteData   = r_memWd;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word-array memory model, in-order response
// scoreboard with latency checks, and one task per scenario.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst;

  lsu_req_if rq();
  lsu_mem_if mm();

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .clk (clk),
    .rst (rst),
    .req (rq.slave),
    .mem (mm.master)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wr_cnt  = 0;
  int rd_cnt  = 0;
  int last_wcyc = 0;
  logic [31:0] last_wa;
  logic [31:0] last_wd;
  logic [31:0] mem_arr [0:1023];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: synchronous write, read data one cycle after the strobe.
  always @(posedge clk) begin
    if (mm.memWriteEnable) begin
      mem_arr[mm.memAddr[11:2]] <= mm.memWriteData;
      wr_cnt    <= wr_cnt + 1;
      last_wa   <= mm.memAddr;
      last_wd   <= mm.memWriteData;
      last_wcyc <= cyc;
    end
    if (mm.memReadEnable) begin
      mm.memReadData <= mem_arr[mm.memAddr[11:2]];
      rd_cnt <= rd_cnt + 1;
    end
  end

  // Response monitor and bus invariants.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mm.memReadEnable && mm.memWriteEnable) begin
          n_tests++; n_fail++;
          $display("FAIL strobe_overlap at cyc %0d: re=1 we=1, required at most one", cyc);
        end
        if ((mm.memReadEnable || mm.memWriteEnable) && (mm.memAddr[1:0] != 2'b00)) begin
          n_tests++; n_fail++;
          $display("FAIL memaddr_align got %h, required word aligned", mm.memAddr);
        end
        if (rq.respValid) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL resp_unexpected at cyc %0d data=%h err=%b, required none", cyc, rq.respData, rq.respError);
          end else begin
            e = sb.pop_front();
            if (rq.respData !== e.data || rq.respError !== e.err || cyc != e.cyc) begin
              n_fail++;
              $display("FAIL resp got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d",
                       rq.respData, rq.respError, cyc, e.data, e.err, e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request once the unit is ready; lat is accept-to-response cycles.
  task automatic send(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] ed, input logic ee, input int lat, input bit push,
                      input bit hold, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!rq.reqReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (rq.reqReady !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready got reqReady=%b after %0d cycles, required 1", rq.reqReady, n);
    end
    rq.reqValid  = 1'b1;
    rq.reqWrite  = w;
    rq.reqFunct3 = f3;
    rq.reqAddr   = a;
    rq.reqData   = d;
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) sb.push_back('{ed, ee, acc + lat - 1});
    if (!hold) rq.reqValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({rq.reqReady, rq.respValid, rq.respError, mm.memReadEnable, mm.memWriteEnable} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl got rdy,rv,err,re,we=%b, required 10000",
               {rq.reqReady, rq.respValid, rq.respError, mm.memReadEnable, mm.memWriteEnable});
    end
    n_tests++;
    if (rq.respData !== 32'h0 || mm.memAddr !== 32'h0 || mm.memWriteData !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data got respData=%h memAddr=%h memWriteData=%h, required all 0",
               rq.respData, mm.memAddr, mm.memWriteData);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rq.reqReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready got %b, required 1", rq.reqReady);
    end
  endtask

  task automatic test_word_round_trip();
    int acc, wc;
    wc = wr_cnt;
    send(1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, 1'b0, acc);
    drain();
    n_tests++;
    if (wr_cnt != wc + 1 || last_wa !== 32'h200 || last_wd !== 32'hDEADBEEF || last_wcyc != acc) begin
      n_fail++;
      $display("FAIL sw_write got n=%0d addr=%h data=%h cyc=%0d, required n=1 addr=00000200 data=deadbeef cyc=%0d",
               wr_cnt - wc, last_wa, last_wd, last_wcyc, acc);
    end
    send(1'b0, 3'b010, 32'h200, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1, 1'b0, acc);
    drain();
  endtask

  task automatic test_subword_loads();
    int acc;
    send(1'b1, 3'b010, 32'h204, 32'h8081F0F1, 32'h0, 1'b0, 2, 1'b1, 1'b0, acc);
    send(1'b0, 3'b000, 32'h205, 32'h0, 32'hFFFFFFF0, 1'b0, 3, 1'b1, 1'b0, acc);
    send(1'b0, 3'b100, 32'h207, 32'h0, 32'h00000080, 1'b0, 3, 1'b1, 1'b0, acc);
    send(1'b0, 3'b001, 32'h206, 32'h0, 32'hFFFF8081, 1'b0, 3, 1'b1, 1'b0, acc);
    send(1'b0, 3'b101, 32'h204, 32'h0, 32'h0000F0F1, 1'b0, 3, 1'b1, 1'b0, acc);
    send(1'b0, 3'b000, 32'h204, 32'h0, 32'hFFFFFFF1, 1'b0, 3, 1'b1, 1'b0, acc);
    send(1'b0, 3'b100, 32'h206, 32'h0, 32'h00000081, 1'b0, 3, 1'b1, 1'b0, acc);
    drain();
  endtask

  task automatic test_rmw();
    int acc, wc;
    send(1'b1, 3'b010, 32'h208, 32'h11223344, 32'h0, 1'b0, 2, 1'b1, 1'b0, acc);
    drain();
    wc = wr_cnt;
    send(1'b1, 3'b000, 32'h209, 32'hFFFFFFAA, 32'h0, 1'b0, 4, 1'b1, 1'b0, acc);
    drain();
    n_tests++;
    if (wr_cnt != wc + 1 || last_wa !== 32'h208 || last_wd !== 32'h1122AA44 || last_wcyc != acc + 2) begin
      n_fail++;
      $display("FAIL sb_rmw got n=%0d addr=%h data=%h cyc=%0d, required n=1 addr=00000208 data=1122aa44 cyc=%0d",
               wr_cnt - wc, last_wa, last_wd, last_wcyc, acc + 2);
    end
    send(1'b1, 3'b001, 32'h20A, 32'h1234BEEF, 32'h0, 1'b0, 4, 1'b1, 1'b0, acc);
    drain();
    n_tests++;
    if (last_wd !== 32'hBEEFAA44) begin
      n_fail++;
      $display("FAIL sh_rmw got data=%h, required beefaa44", last_wd);
    end
    send(1'b0, 3'b010, 32'h208, 32'h0, 32'hBEEFAA44, 1'b0, 3, 1'b1, 1'b0, acc);
    drain();
  endtask

  task automatic test_errors();
    int acc, wc, rc;
    wc = wr_cnt;
    rc = rd_cnt;
    send(1'b0, 3'b010, 32'h201,  32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0, acc);
    send(1'b1, 3'b001, 32'h203,  32'h5555, 32'h0, 1'b1, 1, 1'b1, 1'b0, acc);
    send(1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0, acc);
    send(1'b0, 3'b011, 32'h200,  32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0, acc);
    send(1'b1, 3'b100, 32'h200,  32'h77, 32'h0, 1'b1, 1, 1'b1, 1'b0, acc);
    send(1'b1, 3'b000, 32'hFFFFFFFF, 32'h77, 32'h0, 1'b1, 1, 1'b1, 1'b0, acc);
    drain();
    n_tests++;
    if (wr_cnt != wc || rd_cnt != rc) begin
      n_fail++;
      $display("FAIL err_no_strobes got reads=%0d writes=%0d, required 0 and 0", rd_cnt - rc, wr_cnt - wc);
    end
  endtask

  task automatic test_reset_in_wait();
    int acc, wc;
    send(1'b1, 3'b010, 32'h20C, 32'h55667788, 32'h0, 1'b0, 2, 1'b1, 1'b0, acc);
    drain();
    wc = wr_cnt;
    send(1'b1, 3'b000, 32'h20D, 32'h00000099, 32'h0, 1'b0, 4, 1'b0, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (rq.reqReady !== 1'b1 || rq.respValid !== 1'b0 || mm.memWriteEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_state got rdy=%b rv=%b we=%b, required 1 0 0",
               rq.reqReady, rq.respValid, mm.memWriteEnable);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (wr_cnt != wc) begin
      n_fail++;
      $display("FAIL rst_wait_nowrite got %0d writes, required 0", wr_cnt - wc);
    end
    send(1'b0, 3'b010, 32'h20C, 32'h0, 32'h55667788, 1'b0, 3, 1'b1, 1'b0, acc);
    drain();
  endtask

  task automatic test_reset_in_wr();
    int acc, wc;
    wc = wr_cnt;
    send(1'b1, 3'b010, 32'h210, 32'h12345678, 32'h0, 1'b0, 2, 1'b0, 1'b0, acc);
    n_tests++;
    if (mm.memWriteEnable !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wr_pre got we=%b, required 1", mm.memWriteEnable);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (mm.memWriteEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wr_drop got we=%b, required 0", mm.memWriteEnable);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (wr_cnt != wc) begin
      n_fail++;
      $display("FAIL rst_wr_nowrite got %0d writes, required 0", wr_cnt - wc);
    end
  endtask

  task automatic test_hold_valid();
    int acc, rc;
    bit seen;
    rc = rd_cnt;
    seen = 1'b0;
    send(1'b0, 3'b010, 32'h200, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1, 1'b1, acc);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rq.respValid) begin
        rq.reqValid = 1'b0;
        seen = 1'b1;
      end else begin
        n_tests++;
        if (rq.reqReady !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_ready got %b, required 0", rq.reqReady);
        end
        rq.reqAddr = rq.reqAddr + 32'd4;
      end
    end
    rq.reqValid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    n_tests++;
    if (rd_cnt != rc + 1) begin
      n_fail++;
      $display("FAIL hold_single got %0d reads, required 1", rd_cnt - rc);
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, acc3;
    send(1'b0, 3'b010, 32'h204, 32'h0, 32'h8081F0F1, 1'b0, 3, 1'b1, 1'b0, acc1);
    send(1'b0, 3'b100, 32'h207, 32'h0, 32'h00000080, 1'b0, 3, 1'b1, 1'b0, acc2);
    n_tests++;
    if (acc2 != acc1 + 4) begin
      n_fail++;
      $display("FAIL b2b_accept got accept cyc %0d, required %0d", acc2, acc1 + 4);
    end
    send(1'b1, 3'b000, 32'h204, 32'h0000007E, 32'h0, 1'b0, 4, 1'b1, 1'b0, acc3);
    send(1'b0, 3'b010, 32'h204, 32'h0, 32'h8081F07E, 1'b0, 3, 1'b1, 1'b0, acc1);
    n_tests++;
    if (acc1 != acc3 + 5) begin
      n_fail++;
      $display("FAIL b2b_accept_rmw got accept cyc %0d, required %0d", acc1, acc3 + 5);
    end
    drain();
  endtask

  initial begin
    rst          = 1'b1;
    rq.reqValid  = 1'b0;
    rq.reqWrite  = 1'b0;
    rq.reqFunct3 = 3'b000;
    rq.reqAddr   = 32'h0;
    rq.reqData   = 32'h0;
    test_reset();
    test_word_round_trip();
    test_subword_loads();
    test_rmw();
    test_errors();
    test_reset_in_wait();
    test_reset_in_wr();
    test_hold_valid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
